alu_cmd_dispatcher: RTL and testbench
=====================================

# alu_cmd_dispatcher

Upstream feeder for the 4-bit ALU. Buffers incoming commands (opcode plus two signed 4-bit operands) in a small FIFO and issues at most one command per cycle onto the ALU's `Opcode`/`A`/`B` inputs. It also generates a result-valid strobe aligned with the ALU's one-cycle registered output `C`, so downstream logic samples only real results. Idle ALU cycles never look like valid results.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, 2..16.
- `clk`  in  1: clock; all state updates on posedge.
- `reset`  in  1: asynchronous, active-low. 0 clears all state immediately.
- `cmd_valid`  in  1: command offered this cycle.
- `cmd_ready`  out  1: FIFO can accept. Equals (count != DEPTH).
- `cmd_opcode`  in  opcode_t: Add, Sub, invert_A, reduction_OR_B.
- `cmd_a`, `cmd_b`  in  signed 4 each: operands.
- `issue_en`  in  1: 0 stalls issue; the FIFO still accepts commands.
- `flush`  in  1: synchronous; empties the FIFO.
- `alu_opcode`  out  opcode_t: to ALU `Opcode`, registered.
- `alu_a`, `alu_b`  out  signed 4: to ALU `A`/`B`, registered.
- `alu_issue`  out  1: `alu_*` carry a new command this cycle.
- `res_valid`  out  1: `alu_issue` delayed by one cycle; qualifies ALU `C`.
- `res_tag`  out  3: sequence number of the result flagged by `res_valid`.
- `fifo_count`  out  $clog2(DEPTH)+1: occupancy.
- `drop_err`  out  1: sticky. Set when `cmd_valid` is high and `cmd_ready` is low.

## Operation
- **Push:** on a cycle with `cmd_valid && cmd_ready`, write {opcode, a, b} at the write pointer.
- **Pop:** on a cycle with state RUN, count != 0 and `issue_en`, read the head, register it onto `alu_*`, and set `alu_issue` = 1 for that cycle.
- **FSM states:**
  - IDLE: count == 0.
  - RUN: count != 0 and `issue_en`.
  - STALL: count != 0 and !`issue_en`.
- **FSM transitions:** the next state is evaluated from the post-update count and `issue_en`. Any state goes to IDLE on `flush` or when the last entry pops.
- **Hold:** when not issuing, `alu_*` hold their last values and `alu_issue` = 0.
- **Simultaneous push and pop:** count is unchanged. A push while full is not accepted, even if a pop happens in the same cycle: `cmd_ready` does not look ahead.
- **Empty:** no pass-through. A command pushed into an empty FIFO is issued on the following edge at the earliest.
- **Pointers:** wrap modulo DEPTH. Count saturates at DEPTH and never goes below 0.
- **flush:** resets the pointers and count to 0 and forces `alu_issue` = 0. The same-cycle push is discarded. A `res_valid` already in flight still asserts.
- **res_tag:** a 3-bit counter incremented on every issue; wraps 7 → 0. `res_tag` is the counter value at issue, delayed one cycle.
- **drop_err:** cleared only by reset.

## Timing
- Reset values: `cmd_ready` = 1, `alu_opcode` = Add, `alu_a` = `alu_b` = 0, `alu_issue` = 0, `res_valid` = 0, `res_tag` = 0, `fifo_count` = 0, `drop_err` = 0, state = IDLE.
- Latency: a command accepted at edge N issues at edge N+1 (`alu_issue` high during N+1..N+2). The ALU registers the result at edge N+2; `res_valid` is high during N+2..N+3.
- Throughput: one command per cycle sustained when `issue_en` = 1.
- Reset mid-operation: all state clears asynchronously. In-flight results are abandoned and `res_valid` drops immediately.

## Configuration
- `ALU_DISPATCH_TAG_EN`:
  - Defined: the `res_tag` counter and its pipeline register are built.
  - Undefined: `res_tag` is tied to 0 and no counter logic is synthesized.
- All other behaviour is identical in both builds.

## Structure
- Shared package `ALU_Package` gains:
  - `alu_cmd_t` packed struct {opcode_t op; logic signed [3:0] a, b;}.
  - `dispatch_state_t` enum {IDLE, RUN, STALL}.
  - `opcode_t` stays where it is.
- One sub-module, `alu_cmd_fifo`: storage, pointers and count, with push/pop/flush inputs and full/empty outputs. The FSM, issue registers and tag pipeline live in the top.

## Test plan
- After reset, push (Add, 3, 2) with `issue_en` = 1 → `alu_issue` one cycle after acceptance with `alu_a` = 3, `alu_b` = 2. Next cycle `res_valid` = 1 and ALU `C` = 5, `res_tag` = 0.
- With `issue_en` = 0, push DEPTH = 4 commands → `cmd_ready` = 0, `fifo_count` = 4. A 5th `cmd_valid` sets `drop_err` = 1.
- Raise `issue_en` with the FIFO full → four back-to-back issues in FIFO order; `res_tag` 0,1,2,3 on consecutive `res_valid` cycles.
- Hold `cmd_valid` every cycle with `issue_en` = 1 → `fifo_count` stays 1 and one issue per cycle. Run 10 commands → `res_tag` wraps 7 → 0.
- Fill 3 entries, assert `flush` together with a `cmd_valid` → `fifo_count` = 0, no further `alu_issue`, state IDLE.
- Drive (Sub, -8, 7) and pull `reset` low the cycle after issue → `res_valid`, `alu_a` and `fifo_count` read 0 immediately.

Source files
------------

// File: rtl/alu_cmd_dispatcher_pkg.sv
// ALU_Package: shared types for the 4-bit ALU and its command dispatcher.
//   opcode_t          - ALU operation select (drives ALU Opcode)
//   alu_cmd_t         - one buffered command {op, a, b}
//   dispatch_state_t  - dispatcher FSM states
//   CMD_RESET         - command value the issue registers hold after reset
package ALU_Package;

  typedef enum logic [1:0] {
    Add            = 2'd0,
    Sub            = 2'd1,
    invert_A       = 2'd2,
    reduction_OR_B = 2'd3
  } opcode_t;

  typedef struct packed {
    opcode_t          op;
    logic signed [3:0] a;
    logic signed [3:0] b;
  } alu_cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } dispatch_state_t;

  localparam alu_cmd_t CMD_RESET = '{op: Add, a: 4'sd0, b: 4'sd0};

endpackage

// File: rtl/alu_cmd_dispatcher_fifo.sv
// alu_cmd_fifo: command storage for the ALU dispatcher.
//   DEPTH      - entries, power of two in 2..16
//   clk/reset  - clock, asynchronous active-low reset
//   push/pop   - requests; ignored when full/empty respectively
//   flush      - synchronous clear of pointers and count; overrides push/pop
//   wr_data    - command written on an accepted push
//   rd_data    - head entry (combinational read)
//   full/empty - occupancy flags
//   count      - current occupancy
//   count_nxt  - occupancy after this edge (feeds the dispatcher FSM)
module alu_cmd_fifo
  import ALU_Package::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  alu_cmd_t                 wr_data,
  output alu_cmd_t                 rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   count_nxt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  alu_cmd_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push_ok;
  logic            pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;
  assign rd_data = mem[rd_ptr];

  // Guards on push_ok/pop_ok keep count within 0..DEPTH, so no explicit clamp.
  always_comb begin
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else if (push_ok && !pop_ok) begin
      count_nxt = count + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_nxt = count - 1'b1;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_nxt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/alu_cmd_dispatcher.sv
// alu_cmd_dispatcher: buffers ALU commands and issues at most one per cycle
// onto the registered ALU inputs, with a result-valid strobe aligned to the
// ALU's one-cycle registered output C.
// Optional feature macro: ALU_DISPATCH_TAG_EN builds the res_tag counter;
// without it res_tag is tied to 0.
//   DEPTH                   - FIFO entries (power of two, 2..16)
//   clk / reset             - clock, asynchronous active-low reset
//   cmd_valid / cmd_ready   - command handshake (ready = FIFO not full)
//   cmd_opcode/cmd_a/cmd_b  - incoming command
//   issue_en                - 0 stalls issue, FIFO still accepts
//   flush                   - synchronous FIFO clear, drops same-cycle push
//   alu_opcode/alu_a/alu_b  - registered ALU inputs
//   alu_issue               - alu_* carry a new command this cycle
//   res_valid / res_tag     - qualifies ALU C, with its issue sequence number
//   fifo_count              - FIFO occupancy
//   drop_err                - sticky: command offered while full
module alu_cmd_dispatcher
  import ALU_Package::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  opcode_t                 cmd_opcode,
  input  logic signed [3:0]       cmd_a,
  input  logic signed [3:0]       cmd_b,
  input  logic                    issue_en,
  input  logic                    flush,
  output opcode_t                 alu_opcode,
  output logic signed [3:0]       alu_a,
  output logic signed [3:0]       alu_b,
  output logic                    alu_issue,
  output logic                    res_valid,
  output logic [2:0]              res_tag,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    drop_err
);

  dispatch_state_t              state;
  alu_cmd_t                     cmd_in;
  alu_cmd_t                     head;
  logic                         full;
  logic                         empty;
  logic                         pop;
  logic [$clog2(DEPTH):0]       count_nxt;

  assign cmd_in    = '{op: cmd_opcode, a: cmd_a, b: cmd_b};
  assign cmd_ready = !full;
  // Issue requires the registered RUN state, so a fresh push never passes
  // straight through and raising issue_en from STALL costs one cycle.
  assign pop       = (state == RUN) && !empty && issue_en && !flush;

  alu_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (cmd_valid),
    .pop       (pop),
    .flush     (flush),
    .wr_data   (cmd_in),
    .rd_data   (head),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count),
    .count_nxt (count_nxt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      alu_opcode <= CMD_RESET.op;
      alu_a      <= CMD_RESET.a;
      alu_b      <= CMD_RESET.b;
      alu_issue  <= 1'b0;
      res_valid  <= 1'b0;
      drop_err   <= 1'b0;
    end else begin
      alu_issue <= pop;
      // An in-flight result still reports even across a flush.
      res_valid <= alu_issue;
      if (pop) begin
        alu_opcode <= head.op;
        alu_a      <= head.a;
        alu_b      <= head.b;
      end
      if (cmd_valid && !cmd_ready) drop_err <= 1'b1;
      if (flush || count_nxt == '0) begin
        state <= IDLE;
      end else if (issue_en) begin
        state <= RUN;
      end else begin
        state <= STALL;
      end
    end
  end

`ifdef ALU_DISPATCH_TAG_EN
  logic [2:0] tag_cnt;
  logic [2:0] issue_tag;

  // issue_tag travels with alu_*; res_tag lines it up with res_valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_cnt   <= '0;
      issue_tag <= '0;
      res_tag   <= '0;
    end else begin
      if (pop) begin
        issue_tag <= tag_cnt;
        tag_cnt   <= tag_cnt + 3'd1;
      end
      res_tag <= issue_tag;
    end
  end
`else
  assign res_tag = '0;
`endif

endmodule

// File: tb/tb_alu_cmd_dispatcher.sv
module tb_alu_cmd_dispatcher;
  import ALU_Package::*;

  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [3:0] c;
    int         tag;
  } res_t;

  logic                    clk;
  logic                    reset;
  logic                    cmd_valid;
  logic                    cmd_ready;
  opcode_t                 cmd_opcode;
  logic signed [3:0]       cmd_a;
  logic signed [3:0]       cmd_b;
  logic                    issue_en;
  logic                    flush;
  opcode_t                 alu_opcode;
  logic signed [3:0]       alu_a;
  logic signed [3:0]       alu_b;
  logic                    alu_issue;
  logic                    res_valid;
  logic [2:0]              res_tag;
  logic [$clog2(DEPTH):0]  fifo_count;
  logic                    drop_err;
  logic [3:0]              alu_c;

  int total = 0;
  int bad   = 0;
  int tag_cnt = 0;
  int res_seen = 0;
  alu_cmd_t cmd_q[$];
  res_t     res_q[$];
  alu_cmd_t mon_cmd;
  res_t     mon_res;

  alu_cmd_dispatcher #(
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opcode (cmd_opcode),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .issue_en   (issue_en),
    .flush      (flush),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_issue  (alu_issue),
    .res_valid  (res_valid),
    .res_tag    (res_tag),
    .fifo_count (fifo_count),
    .drop_err   (drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] alu_fn(input opcode_t op, input logic signed [3:0] a,
                                        input logic signed [3:0] b);
    case (op)
      Add:      return a + b;
      Sub:      return a - b;
      invert_A: return ~a;
      default:  return {3'b000, |b};
    endcase
  endfunction

  // Behavioural stand-in for the ALU's registered output C.
  always @(posedge clk or negedge reset) begin
    if (!reset) alu_c <= '0;
    else        alu_c <= alu_fn(alu_opcode, alu_a, alu_b);
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Scoreboard: issues must follow push order; each issue owes one result
  // on the next cycle carrying C and the issue sequence number.
  always @(negedge clk) begin
    if (reset) begin
      if (res_valid) begin
        if (res_q.size() == 0) begin
          chk("res_spurious", 1, 0);
        end else begin
          mon_res = res_q.pop_front();
          res_seen++;
          chk("res_c", int'(alu_c), int'(mon_res.c));
          chk("res_tag", int'(res_tag), mon_res.tag);
        end
      end
      if (alu_issue) begin
        if (cmd_q.size() == 0) begin
          chk("issue_spurious", 1, 0);
        end else begin
          mon_cmd = cmd_q.pop_front();
          chk("iss_op", int'(alu_opcode), int'(mon_cmd.op));
          chk("iss_a", int'(alu_a), int'(mon_cmd.a));
          chk("iss_b", int'(alu_b), int'(mon_cmd.b));
          mon_res.c = alu_fn(mon_cmd.op, mon_cmd.a, mon_cmd.b);
`ifdef ALU_DISPATCH_TAG_EN
          mon_res.tag = tag_cnt;
`else
          mon_res.tag = 0;
`endif
          tag_cnt = (tag_cnt + 1) % 8;
          res_q.push_back(mon_res);
        end
      end
    end
  end

  task automatic do_reset();
    reset     = 1'b0;
    cmd_valid = 1'b0;
    flush     = 1'b0;
    issue_en  = 1'b0;
    cmd_q.delete();
    res_q.delete();
    tag_cnt  = 0;
    res_seen = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic drive_cmd(input opcode_t op, input int a, input int b, input bit accept);
    alu_cmd_t c;
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    cmd_a      = 4'(a);
    cmd_b      = 4'(b);
    c.op = op;
    c.a  = 4'(a);
    c.b  = 4'(b);
    if (accept) cmd_q.push_back(c);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((cmd_q.size() != 0 || res_q.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(tag, int'(cmd_q.size() == 0 && res_q.size() == 0), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] pat;
    reset = 1'b0; cmd_valid = 1'b0; flush = 1'b0; issue_en = 1'b0;
    cmd_opcode = Add; cmd_a = '0; cmd_b = '0;
    #3;
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_op", int'(alu_opcode), int'(Add));
    chk("rst_a", int'(alu_a), 0);
    chk("rst_b", int'(alu_b), 0);
    chk("rst_issue", int'(alu_issue), 0);
    chk("rst_rv", int'(res_valid), 0);
    chk("rst_tag", int'(res_tag), 0);
    chk("rst_count", int'(fifo_count), 0);
    chk("rst_drop", int'(drop_err), 0);
    do_reset();

    // Single command: latency and result alignment.
    issue_en = 1'b1;
    drive_cmd(Add, 3, 2, 1);
    @(negedge clk); chk("no_passthru", int'(alu_issue), 0);
    @(negedge clk);
    chk("lat_issue", int'(alu_issue), 1);
    chk("lat_a", int'(alu_a), 3);
    chk("lat_b", int'(alu_b), 2);
    @(negedge clk);
    chk("lat_rv", int'(res_valid), 1);
    chk("lat_c", int'(alu_c), 5);
    chk("lat_tag", int'(res_tag), 0);
    drain("drain_single");

    // Fill while stalled, then overflow.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_cmd(opcode_t'(i), i + 1, 6 - 3 * i, 1);
      @(negedge clk);
      chk("stall_no_issue", int'(alu_issue), 0);
      chk("fill_count", int'(fifo_count), i + 1);
    end
    chk("full_ready", int'(cmd_ready), 0);
    chk("full_drop0", int'(drop_err), 0);
    drive_cmd(Add, 7, 7, 0);
    @(negedge clk);
    chk("drop_set", int'(drop_err), 1);
    chk("drop_count", int'(fifo_count), 4);

    // Release: one cycle to leave STALL, then four back-to-back issues.
    issue_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pat[i] = alu_issue;
    end
    chk("b2b_pattern", int'(pat), int'(6'b011110));
    drain("drain_b2b");
    chk("drop_sticky", int'(drop_err), 1);

    // Sustained push/issue; tag wraps past 7.
    do_reset();
    issue_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_cmd(opcode_t'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 15)), 1);
      @(negedge clk);
      chk("sus_count", int'(fifo_count), 1);
      if (i > 0) chk("sus_issue", int'(alu_issue), 1);
    end
    drain("drain_sus");
    chk("sus_results", res_seen, 10);

    // Flush with a simultaneous push.
    issue_en = 1'b0;
    for (int i = 0; i < 3; i++) drive_cmd(Sub, i, 1, 1);
    @(negedge clk); chk("pre_flush_count", int'(fifo_count), 3);
    flush = 1'b1;
    drive_cmd(Add, 1, 1, 0);
    flush = 1'b0;
    cmd_q.delete();
    @(negedge clk);
    chk("flush_count", int'(fifo_count), 0);
    chk("flush_ready", int'(cmd_ready), 1);
    issue_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_flush_issue", int'(alu_issue), 0);
    end

    // Asynchronous reset while a result is in flight.
    drive_cmd(Sub, -8, 7, 1);
    drive_cmd(Add, 5, 1, 1);
    drive_cmd(Add, 2, 2, 1);
    @(negedge clk);
    chk("pre_rst_rv", int'(res_valid), 1);
    chk("pre_rst_a", int'(alu_a), 5);
    chk("pre_rst_count", int'(fifo_count), 1);
    #2 reset = 1'b0;
    #1;
    chk("async_rv", int'(res_valid), 0);
    chk("async_a", int'(alu_a), 0);
    chk("async_count", int'(fifo_count), 0);
    chk("async_issue", int'(alu_issue), 0);
    do_reset();
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
